// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: scoreboard-based operand forwarding and load-use stall unit for the mini_rv ID stage.
// Define HAZARD_PERF_EN to add saturating perf_stall / perf_fwd counters.
module hazard_fwd_unit #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1,
  parameter int SEL_W    = $clog2(DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [RA_W-1:0]            id_rs1,
  input  logic [RA_W-1:0]            id_rs2,
  input  logic                       id_re1,
  input  logic                       id_re2,
  input  logic [RA_W-1:0]            id_rd,
  input  logic                       id_we,
  input  logic                       id_is_load,
  input  logic                       flush,
  input  logic [DEPTH*XLEN-1:0]      stage_data,
  input  logic [XLEN-1:0]            rf_rd1,
  input  logic [XLEN-1:0]            rf_rd2,
  output logic [XLEN-1:0]            op_rs1,
  output logic [XLEN-1:0]            op_rs2,
  output logic [SEL_W-1:0]           fwd_sel1,
  output logic [SEL_W-1:0]           fwd_sel2,
  output logic                       stop,
  output logic [$clog2(DEPTH+1)-1:0] inflight
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                perf_stall,
  output logic [31:0]                perf_fwd
`endif
);

  localparam int IW = $clog2(DEPTH+1);

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            ld;
  } sb_entry_t;

  sb_entry_t r_sb [DEPTH];

  logic            w_hit1, w_rdy1, w_hit2, w_rdy2;
  logic [SEL_W-1:0] w_sel1, w_sel2;
  logic            w_stop;
  logic [IW-1:0]   w_cnt;

  // Youngest producer wins: scan oldest to youngest so the last hit is the smallest k.
  function automatic void lookup(input  logic             re,
                                 input  logic [RA_W-1:0]  rs,
                                 output logic             hit,
                                 output logic             rdy,
                                 output logic [SEL_W-1:0] sel);
    hit = 1'b0;
    rdy = 1'b0;
    sel = '0;
    if (re && rs != '0) begin
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (r_sb[k].v && r_sb[k].we && r_sb[k].rd == rs) begin
          hit = 1'b1;
          rdy = !r_sb[k].ld || (k >= LOAD_RDY);
          sel = SEL_W'(k+1);
        end
      end
    end
  endfunction

  always_comb begin
    lookup(id_re1, id_rs1, w_hit1, w_rdy1, w_sel1);
    lookup(id_re2, id_rs2, w_hit2, w_rdy2, w_sel2);
  end

  assign w_stop = id_valid && !flush && ((w_hit1 && !w_rdy1) || (w_hit2 && !w_rdy2));
  assign stop   = w_stop;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    op_rs1   = rf_rd1;
    op_rs2   = rf_rd2;
    if (w_hit1 && w_rdy1) fwd_sel1 = w_sel1;
    if (w_hit2 && w_rdy2) fwd_sel2 = w_sel2;
    for (int k = 0; k < DEPTH; k++) begin
      if (fwd_sel1 == SEL_W'(k+1)) op_rs1 = stage_data[k*XLEN +: XLEN];
      if (fwd_sel2 == SEL_W'(k+1)) op_rs2 = stage_data[k*XLEN +: XLEN];
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < DEPTH; k++) w_cnt = w_cnt + IW'(r_sb[k].v);
  end

  assign inflight = w_cnt;

  // The scoreboard always advances; a stall or flush only replaces the new EX entry with a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the scoreboard is a handful of flops, so every entry is reset; a RAM-style array would not be.
      for (int k = 0; k < DEPTH; k++) r_sb[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every entry read its neighbour's pre-edge value.
      for (int k = 1; k < DEPTH; k++) r_sb[k] <= r_sb[k-1];
      if (flush || w_stop) r_sb[0] <= '0;
      else                 r_sb[0] <= '{v: id_valid, rd: id_rd, we: id_we & id_valid, ld: id_is_load};
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall, r_perf_fwd;
  logic        w_fwd_evt;

  assign w_fwd_evt = id_valid && !w_stop && !flush && ((fwd_sel1 != '0) || (fwd_sel2 != '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_fwd   <= '0;
    end else begin
      if (w_stop && r_perf_stall != 32'hFFFF_FFFF)    r_perf_stall <= r_perf_stall + 32'd1;
      if (w_fwd_evt && r_perf_fwd != 32'hFFFF_FFFF)   r_perf_fwd   <= r_perf_fwd + 32'd1;
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_fwd   = r_perf_fwd;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed plus random checks of two hazard_fwd_unit configurations
// (DEPTH=3/LOAD_RDY=1 and DEPTH=5/LOAD_RDY=2) against an age-based pipeline model.
module tb_hazard_fwd_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              id_valid, id_re1, id_re2, id_we, id_is_load, flush;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [5*XLEN-1:0] sd;
  logic [XLEN-1:0]   rf_rd1, rf_rd2;

  logic [XLEN-1:0] op1_a, op2_a, op1_b, op2_b;
  logic [1:0]      sel1_a, sel2_a, infl_a;
  logic [2:0]      sel1_b, sel2_b, infl_b;
  logic            stop_a, stop_b;

  hazard_fwd_unit #(.XLEN(XLEN), .RA_W(5), .DEPTH(3), .LOAD_RDY(1)) u_dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .stage_data(sd[3*XLEN-1:0]), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .op_rs1(op1_a), .op_rs2(op2_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a),
    .stop(stop_a), .inflight(infl_a));

  hazard_fwd_unit #(.XLEN(XLEN), .RA_W(5), .DEPTH(5), .LOAD_RDY(2)) u_dut5 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .stage_data(sd), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .op_rs1(op1_b), .op_rs2(op2_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b),
    .stop(stop_b), .inflight(infl_b));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: each in-flight instruction remembers the edge it entered EX; its stage is its age.
  typedef struct {
    int         c;
    logic [4:0] rd;
    bit         we;
    bit         ld;
    int         t;
  } ment_t;
  ment_t mq[$];
  bit    exp_stop[2];

  function automatic int depth_of(int c);
    return (c == 0) ? 3 : 5;
  endfunction

  function automatic int lr_of(int c);
    return (c == 0) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void mlookup(input int c, input logic [4:0] rs, input logic re,
                                  output int k, output bit rdy);
    k   = -1;
    rdy = 1'b0;
    if (re && rs != 5'd0) begin
      foreach (mq[i]) begin
        if (mq[i].c == c && mq[i].we && mq[i].rd == rs) begin
          int age = cyc - mq[i].t;
          if (k < 0 || age < k) begin
            k   = age;
            rdy = !mq[i].ld || age >= lr_of(c);
          end
        end
      end
    end
  endfunction

  task automatic drive(input bit v, input int rs1, input bit re1, input int rs2, input bit re2,
                       input int rd, input bit we, input bit ld, input bit fl);
    id_valid   = v;
    id_rs1     = 5'(rs1);
    id_re1     = re1;
    id_rs2     = 5'(rs2);
    id_re2     = re2;
    id_rd      = 5'(rd);
    id_we      = we;
    id_is_load = ld;
    flush      = fl;
    for (int k = 0; k < 5; k++) sd[k*XLEN +: XLEN] = $urandom;
    rf_rd1 = $urandom;
    rf_rd2 = $urandom;
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
          $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
  endtask

  // Compare both DUTs against the model for the currently driven inputs.
  task automatic eval();
    #1;
    for (int c = 0; c < 2; c++) begin
      int          k1, k2, cnt, d;
      bit          r1, r2, st;
      logic [31:0] o_sel1, o_sel2, o_op1, o_op2, o_inf, e_op;
      logic        o_stop;
      d = depth_of(c);
      mlookup(c, id_rs1, id_re1, k1, r1);
      mlookup(c, id_rs2, id_re2, k2, r2);
      st = id_valid && !flush && ((k1 >= 0 && !r1) || (k2 >= 0 && !r2));
      exp_stop[c] = st;
      cnt = 0;
      foreach (mq[i]) if (mq[i].c == c) cnt++;
      if (c == 0) begin
        o_sel1 = 32'(sel1_a); o_sel2 = 32'(sel2_a); o_op1 = op1_a; o_op2 = op2_a;
        o_inf  = 32'(infl_a); o_stop = stop_a;
      end else begin
        o_sel1 = 32'(sel1_b); o_sel2 = 32'(sel2_b); o_op1 = op1_b; o_op2 = op2_b;
        o_inf  = 32'(infl_b); o_stop = stop_b;
      end
      check($sformatf("d%0d.stop@%0d", d, cyc), 32'(o_stop), 32'(st));
      check($sformatf("d%0d.inflight@%0d", d, cyc), o_inf, 32'(cnt));
      if (!(k1 >= 0 && !r1)) begin
        e_op = (k1 >= 0) ? sd[k1*XLEN +: XLEN] : rf_rd1;
        check($sformatf("d%0d.sel1@%0d", d, cyc), o_sel1, 32'(k1 + 1));
        check($sformatf("d%0d.op1@%0d", d, cyc), o_op1, e_op);
      end
      if (!(k2 >= 0 && !r2)) begin
        e_op = (k2 >= 0) ? sd[k2*XLEN +: XLEN] : rf_rd2;
        check($sformatf("d%0d.sel2@%0d", d, cyc), o_sel2, 32'(k2 + 1));
        check($sformatf("d%0d.op2@%0d", d, cyc), o_op2, e_op);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      cyc++;
      for (int c = 0; c < 2; c++)
        if (id_valid && !flush && !exp_stop[c])
          mq.push_back('{c: c, rd: id_rd, we: id_we, ld: id_is_load, t: cyc});
      for (int i = mq.size() - 1; i >= 0; i--)
        if (cyc - mq[i].t >= depth_of(mq[i].c)) mq.delete(i);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(1, 5, 1, 7, 1, 5, 1, 1, 0);
    @(negedge clk);
    eval();
    check("reset.stop", 32'(stop_a), 32'd0);
    check("reset.inflight", 32'(infl_b), 32'd0);
    check("reset.op1", op1_a, rf_rd1);
    reset = 1'b1;

    // EX forward
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); eval(); tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0); sd[0 +: XLEN] = 32'h11; eval();
    check("exfwd.sel1", 32'(sel1_a), 32'd1);
    check("exfwd.op1", op1_a, 32'h11);
    check("exfwd.stop", 32'(stop_a), 32'd0);
    tick();

    // Youngest producer priority
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); eval(); tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); eval(); tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    sd[XLEN +: XLEN] = 32'h22; sd[0 +: XLEN] = 32'h33; eval();
    check("prio.sel1", 32'(sel1_a), 32'd1);
    check("prio.op1", op1_a, 32'h33);
    tick();

    // Load-use: one stall at LOAD_RDY=1, two at LOAD_RDY=2
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0); eval(); tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0); eval();
    check("lu.c1.stop3", 32'(stop_a), 32'd1);
    check("lu.c1.stop5", 32'(stop_b), 32'd1);
    tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0); eval();
    check("lu.c2.stop3", 32'(stop_a), 32'd0);
    check("lu.c2.sel2", 32'(sel2_a), 32'd2);
    check("lu.c2.op2", op2_a, sd[XLEN +: XLEN]);
    check("lu.c2.stop5", 32'(stop_b), 32'd1);
    tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0); eval();
    check("lu.c3.stop5", 32'(stop_b), 32'd0);
    check("lu.c3.sel2_5", 32'(sel2_b), 32'd3);
    tick();

    // x0 is never forwarded
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); eval(); tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0); eval();
    check("x0.sel1", 32'(sel1_a), 32'd0);
    check("x0.op1", op1_a, rf_rd1);
    tick();

    // Flush beats a load-use stall
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0); eval(); tick();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0); eval(); tick();
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0); eval(); tick();
    drive(1, 9, 1, 0, 0, 9, 1, 0, 1); eval();
    check("flush.stop3", 32'(stop_a), 32'd0);
    check("flush.stop5", 32'(stop_b), 32'd0);
    check("flush.infl_before", 32'(infl_a), 32'd3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); eval();
    check("flush.infl_after", 32'(infl_a), 32'd2);
    tick();

    // Deep forwarding on DEPTH=5 and retirement
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0); eval(); tick();
    for (int r = 1; r <= 6; r++) begin
      drive(1, 12, 1, 0, 0, 0, 0, 0, 0); eval();
      if (r == 5) begin
        check("deep.sel1_5", 32'(sel1_b), 32'd5);
        check("deep.op1_5", op1_b, sd[4*XLEN +: XLEN]);
        check("deep.sel1_3", 32'(sel1_a), 32'd0);
      end
      if (r == 6) begin
        check("deep.retired.sel1", 32'(sel1_b), 32'd0);
        check("deep.retired.op1", op1_b, rf_rd1);
      end
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      drive_rand(); eval(); tick();
    end

    // Reset mid-stream takes effect immediately
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0); eval(); tick();
    drive(1, 6, 1, 6, 1, 0, 0, 0, 0);
    reset = 1'b0;
    mq.delete();
    eval();
    check("midrst.stop3", 32'(stop_a), 32'd0);
    check("midrst.stop5", 32'(stop_b), 32'd0);
    check("midrst.infl3", 32'(infl_a), 32'd0);
    check("midrst.infl5", 32'(infl_b), 32'd0);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 200; i++) begin
      drive_rand(); eval(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
